// File: rtl/pipe_perf_pkg.sv
// pipe_perf_pkg: shared definitions for the pipeline performance monitor.
// Holds the monitor FSM state encoding, the readout select value that
// addresses the cycle counter, and the wrap/saturate mode constants.
package pipe_perf_pkg;

  // Encoding is visible on state_o, so the values are fixed.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } mon_state_e;

  // Readout select value addressing the cycle counter; channel k sits at k+1.
  localparam int unsigned SEL_CYCLE = 32'd0;

  // Counter overflow behaviour.
  localparam int unsigned SAT_WRAP = 32'd0;
  localparam int unsigned SAT_SAT  = 32'd1;

endpackage

// File: rtl/pipe_perf_monitor_counter.sv
// perf_counter: one CNT_W-bit event counter with enable, synchronous clear,
// wrap-or-saturate overflow handling and a sticky overflow flag.
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - asynchronous active-low reset
//   clr_i  - synchronous clear of count and flag (wins over en_i)
//   en_i   - count one this cycle
//   cnt_o  - current (registered) count
//   nxt_o  - value the count takes on this edge ignoring clr_i; this is what
//            a snapshot taken in the same cycle must capture
//   ovf_o  - sticky overflow/saturation flag
module perf_counter
  import pipe_perf_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned SAT_MODE = SAT_WRAP
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] nxt_o,
  output logic             ovf_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d, nxt_s;
  logic [CNT_W:0]   sum_s;
  logic             carry_s;
  logic             ovf_q, ovf_d;

  // Increment with a carry bit, then resolve wrap/saturate and clear.
  always_comb begin
    sum_s   = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    carry_s = sum_s[CNT_W];
    if (!en_i) begin
      nxt_s = cnt_q;
    end else if (carry_s && (SAT_MODE == SAT_SAT)) begin
      nxt_s = cnt_q;               // already all-ones: hold
    end else begin
      nxt_s = sum_s[CNT_W-1:0];    // wraps to 0 on carry in wrap mode
    end
    if (clr_i) begin
      cnt_d = {CNT_W{1'b0}};
      ovf_d = 1'b0;
    end else begin
      cnt_d = nxt_s;
      ovf_d = ovf_q | (en_i & carry_s);
    end
  end

  // Count and flag registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= {CNT_W{1'b0}};
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign nxt_o = nxt_s;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/pipe_perf_monitor.sv
// pipe_perf_monitor: cycle counter plus NUM_EVT qualified event counters for
// the 5-stage pipeline, with a cycle-limit stop, a snapshot shadow bank and a
// one-cycle-latency indexed readout of that shadow bank.
// Ports:
//   clk_i, rst_i (async active-low)
//   start_i   - arms counting from IDLE; low in RUN pauses counting
//   clr_i     - synchronous clear of live counters, flags and FSM
//   limit_i   - cycle limit (0 = unlimited), sampled while IDLE
//   evt_i, inh_i - per-channel event and inhibit
//   snap_i    - copy live counters (post-increment) into the shadow bank
//   rd_en_i, rd_sel_i - readout request/select (0 = cycles, k = channel k-1)
//   rd_data_o, rd_valid_o - readout result, one cycle after the request
//   ovf_o     - sticky overflow flags, bit 0 = cycle counter
//   state_o, done_o - FSM state and DONE indication
module pipe_perf_monitor
  import pipe_perf_pkg::*;
#(
  parameter int unsigned NUM_EVT  = 4,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned SAT_MODE = 0,
  parameter int unsigned SEL_W    = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               clr_i,
  input  logic [CNT_W-1:0]   limit_i,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic [NUM_EVT-1:0] inh_i,
  input  logic               snap_i,
  input  logic               rd_en_i,
  input  logic [SEL_W-1:0]   rd_sel_i,
  output logic [CNT_W-1:0]   rd_data_o,
  output logic               rd_valid_o,
  output logic [NUM_EVT:0]   ovf_o,
  output logic [1:0]         state_o,
  output logic               done_o
);

  localparam int unsigned NCNT = NUM_EVT + 1;

  mon_state_e                   state_q;
  logic                         done_q;
  logic [CNT_W-1:0]             limit_q;
  logic                         run_en_s;
  logic [NCNT-1:0]              cnt_en_s;
  logic [NCNT-1:0][CNT_W-1:0]   cnt_s;
  logic [NCNT-1:0][CNT_W-1:0]   nxt_s;
  logic [NCNT-1:0]              ovf_s;
  logic [NCNT-1:0][CNT_W-1:0]   shadow_q;
  logic [CNT_W-1:0]             rd_mux_s;
  logic [CNT_W-1:0]             rd_data_q;
  logic                         rd_valid_q;

  // Counting happens only in RUN with start_i held; dropping start_i pauses.
  assign run_en_s = (state_q == ST_RUN) && start_i;
  assign cnt_en_s = {evt_i & ~inh_i & {NUM_EVT{run_en_s}}, run_en_s};

  // Index 0 is the cycle counter, index k+1 is event channel k.
  for (genvar g = 0; g < NCNT; g++) begin : g_cnt
    perf_counter #(
      .CNT_W   (CNT_W),
      .SAT_MODE(SAT_MODE)
    ) u_cnt (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .clr_i(clr_i),
      .en_i (cnt_en_s[g]),
      .cnt_o(cnt_s[g]),
      .nxt_o(nxt_s[g]),
      .ovf_o(ovf_s[g])
    );
  end

  // Monitor FSM with registered done flag and limit latch.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      limit_q <= {CNT_W{1'b0}};
    end else begin
      if (state_q == ST_IDLE) begin
        limit_q <= limit_i;
      end else begin
        limit_q <= limit_q;
      end
      if (clr_i) begin
        state_q <= ST_IDLE;
        done_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start_i) begin
              state_q <= ST_RUN;
            end else begin
              state_q <= ST_IDLE;
            end
            done_q <= 1'b0;
          end
          ST_RUN: begin
            // Stop on the edge where the cycle count reaches the limit.
            if (run_en_s && (limit_q != {CNT_W{1'b0}}) && (nxt_s[SEL_CYCLE] == limit_q)) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RUN;
              done_q  <= 1'b0;
            end
          end
          ST_DONE: begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
          default: begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Readout mux over the shadow bank; selects beyond the bank read as zero.
  always_comb begin
    rd_mux_s = {CNT_W{1'b0}};
    for (int k = 0; k < NCNT; k++) begin
      if (rd_sel_i == SEL_W'(k)) begin
        rd_mux_s = shadow_q[k];
      end else begin
        rd_mux_s = rd_mux_s;
      end
    end
  end

  // Shadow bank capture and registered readout (reads see the pre-snap bank).
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      shadow_q   <= '0;
      rd_data_q  <= {CNT_W{1'b0}};
      rd_valid_q <= 1'b0;
    end else begin
      if (snap_i) begin
        shadow_q <= nxt_s;
      end else begin
        shadow_q <= shadow_q;
      end
      if (rd_en_i) begin
        rd_data_q <= rd_mux_s;
      end else begin
        rd_data_q <= rd_data_q;
      end
      rd_valid_q <= rd_en_i;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign ovf_o      = ovf_s;
  assign state_o    = state_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Directed bench for pipe_perf_monitor: a 32-bit wrap instance for the main
// scenarios plus two 4-bit instances (wrap and saturate) for overflow.
module tb_pipe_perf_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, clr, snap, rd_en;
  logic [31:0] limit;
  logic [3:0]  evt, inh, rd_sel;
  logic [31:0] rd_data;
  logic        rd_valid, done;
  logic [4:0]  ovf;
  logic [1:0]  state;

  logic        s_start, s_snap, s_rd_en;
  logic [3:0]  s_evt, s_rd_sel;
  logic [3:0]  w_rd_data, t_rd_data;
  logic        w_rd_valid, t_rd_valid, w_done, t_done;
  logic [4:0]  w_ovf, t_ovf;
  logic [1:0]  w_state, t_state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_perf_monitor #(.NUM_EVT(4), .CNT_W(32), .SAT_MODE(0), .SEL_W(4)) u_dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .clr_i(clr), .limit_i(limit),
    .evt_i(evt), .inh_i(inh), .snap_i(snap), .rd_en_i(rd_en), .rd_sel_i(rd_sel),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid), .ovf_o(ovf), .state_o(state),
    .done_o(done)
  );

  pipe_perf_monitor #(.NUM_EVT(4), .CNT_W(4), .SAT_MODE(0), .SEL_W(4)) u_wrap (
    .clk_i(clk), .rst_i(rst_n), .start_i(s_start), .clr_i(1'b0), .limit_i(4'd0),
    .evt_i(s_evt), .inh_i(4'd0), .snap_i(s_snap), .rd_en_i(s_rd_en), .rd_sel_i(s_rd_sel),
    .rd_data_o(w_rd_data), .rd_valid_o(w_rd_valid), .ovf_o(w_ovf), .state_o(w_state),
    .done_o(w_done)
  );

  pipe_perf_monitor #(.NUM_EVT(4), .CNT_W(4), .SAT_MODE(1), .SEL_W(4)) u_sat (
    .clk_i(clk), .rst_i(rst_n), .start_i(s_start), .clr_i(1'b0), .limit_i(4'd0),
    .evt_i(s_evt), .inh_i(4'd0), .snap_i(s_snap), .rd_en_i(s_rd_en), .rd_sel_i(s_rd_sel),
    .rd_data_o(t_rd_data), .rd_valid_o(t_rd_valid), .ovf_o(t_ovf), .state_o(t_state),
    .done_o(t_done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; clr = 1'b0; snap = 1'b0; rd_en = 1'b0;
    limit = 32'd0; evt = 4'd0; inh = 4'd0; rd_sel = 4'd0;
    s_start = 1'b0; s_snap = 1'b0; s_rd_en = 1'b0; s_evt = 4'd0; s_rd_sel = 4'd0;

    // Reset state
    repeat (2) tick();
    check("rst_state", state, 2'b00);
    check("rst_done", done, 1'b0);
    check("rst_ovf", ovf, 5'd0);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_rd_data", rd_data, 32'd0);
    #2 rst_n = 1'b1;
    tick();

    // Limit 64 with channel 0 firing every cycle
    limit = 32'd64; evt = 4'b0001; start = 1'b1;
    tick();
    check("enter_run", state, 2'b01);
    repeat (63) tick();
    check("run_at_63", state, 2'b01);
    check("done_at_63", done, 1'b0);
    tick();
    check("done_state", state, 2'b10);
    check("done_flag", done, 1'b1);
    evt = 4'd0;
    tick();
    check("done_hold", state, 2'b10);
    snap = 1'b1; tick(); snap = 1'b0;
    rd_en = 1'b1; rd_sel = 4'd0; tick();
    check("lim_cycle", rd_data, 32'd64);
    check("lim_valid", rd_valid, 1'b1);
    rd_sel = 4'd1; tick();
    check("lim_ch0", rd_data, 32'd64);
    rd_sel = 4'd5; tick();
    check("sel_oob5", rd_data, 32'd0);
    check("sel_oob5_valid", rd_valid, 1'b1);
    rd_sel = 4'd15; tick();
    check("sel_oob15", rd_data, 32'd0);
    rd_en = 1'b0; tick();
    check("valid_pulse", rd_valid, 1'b0);
    check("lim_no_ovf", ovf, 5'd0);

    // Clear in DONE: back to IDLE, shadow kept, live counters zeroed
    start = 1'b0; clr = 1'b1; tick(); clr = 1'b0;
    check("clr_state", state, 2'b00);
    check("clr_done", done, 1'b0);
    check("clr_ovf", ovf, 5'd0);
    rd_en = 1'b1; rd_sel = 4'd0; tick(); rd_en = 1'b0;
    check("clr_shadow_kept", rd_data, 32'd64);
    snap = 1'b1; tick(); snap = 1'b0;
    rd_en = 1'b1; rd_sel = 4'd0; tick();
    check("clr_live_cycle", rd_data, 32'd0);
    rd_sel = 4'd1; tick(); rd_en = 1'b0;
    check("clr_live_ch0", rd_data, 32'd0);

    // Inhibit on 3 of 10 event cycles; snapshot at cycle 10
    limit = 32'd0; start = 1'b1; tick();
    for (int i = 1; i <= 10; i++) begin
      evt  = 4'b0001;
      inh  = (i == 2 || i == 5 || i == 9) ? 4'b0001 : 4'b0000;
      snap = (i == 10);
      tick();
    end
    evt = 4'd0; inh = 4'd0; snap = 1'b0;
    rd_en = 1'b1; rd_sel = 4'd1; tick();
    check("inh_ch0", rd_data, 32'd7);
    rd_sel = 4'd0; tick(); rd_en = 1'b0;
    check("snap10_cycle", rd_data, 32'd10);
    repeat (7) tick();
    snap = 1'b1; rd_en = 1'b1; rd_sel = 4'd0; tick(); snap = 1'b0;
    check("read_in_snap", rd_data, 32'd10);
    tick();
    check("snap20_cycle", rd_data, 32'd20);

    // Pause: start low in RUN holds the counters
    start = 1'b0; rd_en = 1'b0;
    repeat (3) tick();
    check("pause_state", state, 2'b01);
    snap = 1'b1; tick(); snap = 1'b0;
    rd_en = 1'b1; rd_sel = 4'd0; tick();
    check("pause_cycle", rd_data, 32'd21);
    rd_sel = 4'd2; tick();
    check("idle_ch1", rd_data, 32'd0);

    // Asynchronous reset between edges while running
    start = 1'b1; rd_sel = 4'd0; tick();
    check("pre_rst_valid", rd_valid, 1'b1);
    rd_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_state", state, 2'b00);
    check("arst_done", done, 1'b0);
    check("arst_valid", rd_valid, 1'b0);
    check("arst_data", rd_data, 32'd0);
    check("arst_ovf", ovf, 5'd0);
    start = 1'b0;
    #3 rst_n = 1'b1;
    repeat (3) tick();
    check("post_rst_idle", state, 2'b00);
    snap = 1'b1; tick(); snap = 1'b0;
    rd_en = 1'b1; rd_sel = 4'd0; tick(); rd_en = 1'b0;
    check("post_rst_cycle", rd_data, 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    check("post_rst_run", state, 2'b01);

    // 4-bit counters: 17 events on channel 1, wrap vs saturate
    s_start = 1'b1; tick();
    for (int i = 1; i <= 17; i++) begin
      s_evt  = 4'b0010;
      s_snap = (i == 17);
      tick();
    end
    s_evt = 4'd0; s_snap = 1'b0;
    s_rd_en = 1'b1; s_rd_sel = 4'd2; tick();
    check("wrap_ch1", w_rd_data, 4'd1);
    check("sat_ch1", t_rd_data, 4'd15);
    check("wrap_ovf2", w_ovf[2], 1'b1);
    check("sat_ovf2", t_ovf[2], 1'b1);
    check("wrap_ovf1", w_ovf[1], 1'b0);
    s_rd_sel = 4'd0; tick(); s_rd_en = 1'b0;
    check("wrap_cycle", w_rd_data, 4'd1);
    check("sat_cycle", t_rd_data, 4'd15);
    check("wrap_ovf0", w_ovf[0], 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_perf_monitor.md
Name: pipe_perf_monitor

Overview:
Synthesisable, parametrised event-counter bank for the 5-stage pipelined CPU. It counts cycles and per-channel pipeline events (stall, flush, retire, …), with per-channel inhibit qualification and a cycle-limit stop. It provides a snapshot shadow bank and an indexed readout port. It replaces ad-hoc bench-side stall/flush counting with in-design counters usable by both the bench and the CPU debug path.

Parameters:
NUM_EVT, 4, number of event channels (1..16)
CNT_W, 32, width of every counter, including the cycle counter
SAT_MODE, 0, 0 = counters wrap to 0 at 2^CNT_W, 1 = counters saturate at all-ones
SEL_W, 4, width of the readout select; must satisfy 2^SEL_W >= NUM_EVT+1

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-low reset
start_i  in  1  level; arms counting from IDLE
clr_i  in  1  synchronous clear of live counters, overflow flags and FSM
limit_i  in  CNT_W  cycle limit; 0 = unlimited; sampled only in IDLE
evt_i  in  NUM_EVT  per-channel event pulse, one count per cycle
inh_i  in  NUM_EVT  per-channel inhibit; event counted only if evt_i[k] && !inh_i[k]
snap_i  in  1  copy all live counters into the shadow bank
rd_en_i  in  1  readout request
rd_sel_i  in  SEL_W  0 = cycle counter, k = event channel k-1
rd_data_o  out  CNT_W  shadow value of the selected counter
rd_valid_o  out  1  rd_data_o valid
ovf_o  out  NUM_EVT+1  sticky overflow/saturation flag per counter; bit 0 = cycle counter
state_o  out  2  00 IDLE, 01 RUN, 10 DONE
done_o  out  1  high while in DONE

Behaviour:
- Reset (rst_i low, asynchronous): all live and shadow counters = 0; ovf_o = 0; rd_data_o = 0; rd_valid_o = 0; state = IDLE; done_o = 0; latched limit = 0.
- FSM transitions:
  - IDLE: latch limit_i each cycle. start_i = 1 -> RUN on the next edge. No counting occurs in the transition cycle.
  - RUN: cycle counter += 1 every cycle. Event channel k += 1 when evt_i[k] && !inh_i[k].
  - RUN -> DONE: on the edge where the cycle counter becomes equal to a nonzero latched limit. Events in that same cycle are counted.
  - DONE: all counters hold. Snapshots and reads remain legal. Exit only via clr_i or reset.
  - start_i deasserted in RUN: hold (pause) without leaving RUN. Counting resumes when start_i is reasserted.
- clr_i: highest synchronous priority. On the next edge, live counters = 0, ovf_o = 0, state = IDLE. The shadow bank is not cleared.
- Overflow:
  - SAT_MODE = 0: all-ones + 1 -> 0 and the flag is set.
  - SAT_MODE = 1: the counter holds all-ones and the flag is set.
  - Flags are sticky until clr_i or reset.
- Snapshot: snap_i captures the post-increment values of the same edge, i.e. the values the live counters take on that edge. snap_i with clr_i in the same cycle captures the pre-clear post-increment values.
- Readout:
  - 1-cycle latency: rd_en_i at edge N -> rd_data_o and rd_valid_o = 1 after edge N. rd_valid_o is a single-cycle pulse per request.
  - Back-to-back reads are allowed every cycle.
  - rd_sel_i > NUM_EVT returns 0 with rd_valid_o = 1.
  - A read in the same cycle as snap_i returns the old shadow value.
- All arithmetic is unsigned CNT_W. Adders are CNT_W+1 wide to detect carry.

Decomposition:
- Shared package pipe_perf_pkg: FSM state encoding (IDLE/RUN/DONE), readout select constant for the cycle counter (0), SAT_MODE constants.
- One sub-module, perf_counter (single CNT_W counter with enable, clear, wrap/saturate and sticky overflow). Instantiated NUM_EVT+1 times in a generate loop.
- Top level contains the FSM, the shadow bank and the readout mux.

Test Plan:
- Reset then start, limit_i = 64, evt_i[0] = 1 every cycle -> state_o = 10 and done_o = 1 after 64 RUN cycles; read sel 0 and sel 1 after snapshot -> 64 and 64.
- Channel 0 stall with inh_i[0] = 1 on 3 of 10 event cycles (branch-coincident stalls) -> channel 0 reads 7.
- CNT_W = 4, SAT_MODE = 0, 17 events on channel 1 -> value 1, ovf_o[2] = 1. With SAT_MODE = 1 -> value 15, ovf_o[2] = 1.
- snap_i at cycle 10, continue to 20, read sel 0 -> 10. Second snap then read -> 20. A read in the snap cycle returns 10.
- rst_i asserted low mid-RUN (asynchronously, between edges) -> all outputs zero immediately, state IDLE. After release, counting does not resume until start_i.
- clr_i in DONE -> IDLE, live counters 0, shadow retains the old values, ovf_o cleared.
